muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with its own HI/LO register pair, replacing the fixed 32-bit multiply-only block beside the datapath ALU.
- Supports signed and unsigned multiply and divide through a start/busy/done handshake.
- Provides direct HI/LO writes for MTHI/MTLO.
- The control unit stalls on busy and reads hi/lo through the register write-data mux.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply and divide with its own HI/LO pair.
// Shift-add multiply (LSB first) and restoring divide (MSB first) share one
// working accumulator. Operands are reduced to magnitudes on entry, and the
// signs are applied in the FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand magnitudes: only signed ops (op[0]==0) take the absolute value.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

    // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {1'b0, {WIDTH{1'b0}}});

    // Divide step: shift the next dividend bit into the (WIDTH+1)-bit remainder and trial-subtract.
    logic [WIDTH:0] div_shift, div_diff;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    // Sign fix-up applied to the final magnitudes.
    logic [PW-1:0]    prod_mag, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign prod_mag = {acc_hi_q, acc_lo_q};
    assign prod_fix = (sa_q ^ sb_q) ? (~prod_mag + PW'(1)) : prod_mag;
    assign quo_fix  = (sa_q ^ sb_q) ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
    assign rem_fix  = sa_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    opb_d    = b_mag;
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    if (op[1] && (b == '0)) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    acc_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[PW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed tests with a result/timing model checked every cycle.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    logic [1:0]  state_out;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;
    logic [1:0]  state8;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clock(clk), .reset(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo), .state_out(state_out)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clock(clk), .reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(wdata8),
        .busy(busy8), .done(done8), .div_zero(dz8),
        .hi(hi8), .lo(lo8), .state_out(state8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic for WIDTH=32, computed with wide native operators.
    task automatic compute(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] rh, output logic [31:0] rl);
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0]        up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
            2'b01: begin up = {32'd0, x} * {32'd0, y}; rh = up[63:32]; rl = up[31:0]; end
            2'b10: if (y != 0) begin sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0]; end
            default: if (y != 0) begin rl = x / y; rh = x % y; end
        endcase
    endtask

    // Timing model: an accepted op keeps busy for WIDTH+2 cycles, results appear
    // in the last busy cycle, done pulses in the cycle after. Divide by zero: one busy cycle.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_dz, m_done;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 1) begin m_hi = p_hi; m_lo = p_lo; end
                if (m_left == 0) m_done = 1'b1;
            end else if (start) begin
                compute(op, a, b, p_hi, p_lo);
                m_dz   = op[1] && (b == 32'd0);
                m_left = m_dz ? 1 : 34;
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    function automatic logic [1:0] exp_state(input int l);
        if (l == 0)      return 2'b00;
        else if (l == 1) return 2'b11;
        else if (l == 2) return 2'b10;
        else             return 2'b01;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy",     64'(busy),      64'(m_left > 0));
            check("done",     64'(done),      64'(m_done));
            check("div_zero", 64'(div_zero),  64'(m_dz));
            check("hi",       64'(hi),        64'(m_hi));
            check("lo",       64'(lo),        64'(m_lo));
            check("state",    64'(state_out), 64'(exp_state(m_left)));
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #2;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", lat);
        end
    endtask

    task automatic write_hl(input logic wh, input logic wl, input logic [31:0] d);
        @(posedge clk); #2;
        hi_we = wh; lo_we = wl; wdata = d;
        @(posedge clk); #2;
        hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_chk(input string nm, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        launch(o, x, y);
        wait_done(lat);
        check({nm, "_lat"}, 64'(lat), 64'd34);
        check({nm, "_hi"}, 64'(hi), 64'(eh));
        check({nm, "_lo"}, 64'(lo), 64'(el));
        check({nm, "_model_hi"}, 64'(m_hi), 64'(eh));
        check({nm, "_model_lo"}, 64'(m_lo), 64'(el));
    endtask

    initial begin
        int lat;
        int done_cnt;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wdata8 = '0;
        @(posedge clk); #2;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_hi",    64'(hi),        64'd0);
        check("rst_lo",    64'(lo),        64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_state", 64'(state_out), 64'd0);

        run_chk("mult_neg3x5",  2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_chk("multu_ones",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_chk("mult_ones",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_chk("div_neg7by2",  2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_chk("divu_7by2",    2'b11, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
        run_chk("div_minby_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_chk("div_7by_m2",   2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        // Direct writes, both in one cycle, then individually.
        write_hl(1'b1, 1'b1, 32'h5A5A_5A5A);
        check("wr_both_hi", 64'(hi), 64'h5A5A_5A5A);
        check("wr_both_lo", 64'(lo), 64'h5A5A_5A5A);
        write_hl(1'b1, 1'b0, 32'h1111_1111);
        write_hl(1'b0, 1'b1, 32'h2222_2222);
        check("wr_hi", 64'(hi), 64'h1111_1111);
        check("wr_lo", 64'(lo), 64'h2222_2222);

        // Divide by zero: early done, hi/lo untouched.
        launch(2'b11, 32'd7, 32'd0);
        wait_done(lat);
        check("dz_lat",  64'(lat),      64'd1);
        check("dz_flag", 64'(div_zero), 64'd1);
        check("dz_hi",   64'(hi),       64'h1111_1111);
        check("dz_lo",   64'(lo),       64'h2222_2222);

        // start with hi_we in the same cycle: the write is dropped.
        @(posedge clk); #2;
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        start = 1'b0; hi_we = 1'b0;
        wait_done(lat);
        check("drop_hi",  64'(hi),       64'd0);
        check("drop_lo",  64'(lo),       64'd6);
        check("drop_dz",  64'(div_zero), 64'd0);

        // Start and lo_we while busy are ignored.
        launch(2'b00, 32'd7, 32'hFFFF_FFFE);
        repeat (9) @(posedge clk);
        #2 op = 2'b01; a = 32'd100; b = 32'd100; start = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
        @(posedge clk); #2;
        start = 1'b0; lo_we = 1'b0;
        wait_done(lat);
        check("busy_ign_lat", 64'(lat), 64'd24);
        check("busy_ign_hi",  64'(hi),  64'hFFFF_FFFF);
        check("busy_ign_lo",  64'(lo),  64'hFFFF_FFF2);

        // Reset in the middle of an operation.
        launch(2'b11, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 64'(state_out), 64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_hi",    64'(hi),        64'd0);
        check("mid_rst_lo",    64'(lo),        64'd0);
        done_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);

        // 8-bit instance: MULT 0x80 * 0x80.
        @(posedge clk); #2;
        op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        for (int i = 0; i < 100 && !done8; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        check("w8_done", 64'(done8), 64'd1);
        check("w8_lat",  64'(lat),   64'd10);
        check("w8_hi",   64'(hi8),   64'h40);
        check("w8_lo",   64'(lo8),   64'h00);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
